// File: rtl/dsm_cic_decimator_if.sv
// Symbol-in / sample-out bundle for the CIC decimator.
// Latency: n/a (wires only).
// Backpressure: none; the source presents one symbol per enabled cycle.
interface dsm_cic_decimator_if #(
  parameter int T_BITS = 15
);
  logic              sample_en;
  logic [1:0]        pwm_in;
  logic [T_BITS-1:0] dout;
  logic              dout_valid;
  logic              sym_err;

  // Symbol source / sample consumer side.
  modport master (
    output sample_en,
    output pwm_in,
    input  dout,
    input  dout_valid,
    input  sym_err
  );

  // Decimator side.
  modport slave (
    input  sample_en,
    input  pwm_in,
    output dout,
    output dout_valid,
    output sym_err
  );
endinterface

// File: rtl/dsm_cic_decimator.sv
// 3rd-order CIC decimator turning the 3-level modulator symbol stream into signed samples.
// Latency: dout/dout_valid register one cycle after the R-th enabled symbol of each window.
// Backpressure: none; one symbol is consumed every cycle sample_en is high, gaps just stretch the period.
module dsm_cic_decimator #(
  parameter int T_BITS   = 15,
  parameter int DEC_LOG2 = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  dsm_cic_decimator_if.slave   bus
);

  localparam int W  = 2 + 3 * DEC_LOG2;
  localparam int SH = 3 * DEC_LOG2 - (T_BITS - 2);

  if (DEC_LOG2 < 2 || DEC_LOG2 > 8 || SH < 0) begin : g_bad_params
    $error("dsm_cic_decimator: DEC_LOG2 must be 2..8 and 3*DEC_LOG2 >= T_BITS-2");
  end

  logic signed [W-1:0]   x;
  logic                  illegal;
  logic signed [W-1:0]   i1, i2, i3;
  logic signed [W-1:0]   d1, d2, d3;
  logic signed [W-1:0]   c1, c2;
  logic [T_BITS-1:0]     y;
  logic [DEC_LOG2-1:0]   cnt;
  logic                  tick;
  logic [T_BITS-1:0]     dout_q;
  logic                  dout_valid_q;
  logic                  sym_err_q;

  // Symbol decode: 01 -> +1, 11 -> -1, 00 and illegal 10 -> 0.
  always_comb begin
    x       = '0;
    illegal = 1'b0;
    case (bus.pwm_in)
      2'b01:   x = {{(W-1){1'b0}}, 1'b1};
      2'b11:   x = '1;
      2'b10:   illegal = 1'b1;
      default: x = '0;
    endcase
  end

  assign tick = bus.sample_en && (cnt == {DEC_LOG2{1'b1}});

  // Integrator cascade; modulo-2^W wrap is cancelled by the combs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else if (bus.sample_en) begin
      i1 <= i1 + x;
      i2 <= i2 + i1;
      i3 <= i3 + i2;
    end
  end

  // Decimation counter, wraps naturally at R-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (bus.sample_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // First two comb stages from the pre-update i3.
  always_comb begin
    c1 = i3 - d1;
    c2 = c1 - d2;
  end

  // Last comb stage: only the bits that survive the output shift are formed;
  // the discarded low bits contribute just their borrow.
  if (SH == 0) begin : g_noshift
    assign y = c2 - d3;
  end else begin : g_shift
    logic borrow;
    assign borrow = c2[SH-1:0] < d3[SH-1:0];
    assign y      = c2[W-1:SH] - d3[W-1:SH] - T_BITS'(borrow);
  end

  // Comb delay line, advanced once per output sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (tick) begin
      d1 <= i3;
      d2 <= c1;
      d3 <= c2;
    end
  end

  // Output sample register and one-cycle strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= tick;
      if (tick) begin
        dout_q <= y;
      end
    end
  end

  // Sticky illegal-symbol flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sym_err_q <= 1'b0;
    end else if (bus.sample_en && illegal) begin
      sym_err_q <= 1'b1;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.sym_err    = sym_err_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Self-checking bench for dsm_cic_decimator.
// Latency: n/a.
// Backpressure: n/a.
module tb_dsm_cic_decimator;

  localparam int T_BITS   = 15;
  localparam int DEC_LOG2 = 6;
  localparam int R        = 1 << DEC_LOG2;
  localparam int SH       = 3 * DEC_LOG2 - (T_BITS - 2);

  logic clock = 1'b0;
  logic reset = 1'b1;

  dsm_cic_decimator_if #(.T_BITS(T_BITS)) bus ();

  dsm_cic_decimator #(.T_BITS(T_BITS), .DEC_LOG2(DEC_LOG2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: every enabled symbol value since reset.
  int hist[$];
  int m_cnt;
  bit m_err;
  int cyc;

  typedef struct {
    string             name;
    int                mode;
    logic [T_BITS-1:0] steady;
    int                period;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic longint cb2(input longint a);
    return (a < 2) ? 64'sd0 : a * (a - 1) / 2;
  endfunction

  // CIC impulse response delayed by three symbols: third difference of C(m,2) at stride R.
  function automatic longint h(input int m);
    return cb2(m) - 3 * cb2(m - R) + 3 * cb2(m - 2 * R) - cb2(m - 3 * R);
  endfunction

  // Output produced when the symbol with index n is the last of its window.
  function automatic logic [T_BITS-1:0] model_out(input int n);
    longint acc;
    int     lo;
    acc = 0;
    lo  = n - 1 - 3 * R;
    if (lo < 0) lo = 0;
    for (int j = lo; j < n; j++) acc += longint'(hist[j]) * h(n - 1 - j);
    acc = acc >>> SH;
    return acc[T_BITS-1:0];
  endfunction

  task automatic model_clear();
    hist.delete();
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // Apply one cycle of input, then compare the registered outputs with the model.
  task automatic step(input logic en, input logic [1:0] sym);
    logic              ev;
    logic [T_BITS-1:0] ed;
    int                xv;
    bus.sample_en = en;
    bus.pwm_in    = sym;
    ev = 1'b0;
    ed = '0;
    if (en) begin
      if (m_cnt % R == R - 1) begin
        ev = 1'b1;
        ed = model_out(m_cnt);
      end
      xv = (sym == 2'b01) ? 1 : (sym == 2'b11) ? -1 : 0;
      hist.push_back(xv);
      m_cnt++;
      if (sym == 2'b10) m_err = 1'b1;
    end
    @(posedge clock);
    #1;
    cyc++;
    chk("valid", 32'(bus.dout_valid), 32'(ev));
    if (ev) chk("dout", 32'(bus.dout), 32'(ed));
    chk("sym_err", 32'(bus.sym_err), 32'(m_err));
  endtask

  task automatic apply_reset();
    bus.sample_en = 1'b0;
    bus.pwm_in    = 2'b00;
    reset = 1'b0;
    #1;
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_valid", 32'(bus.dout_valid), 0);
    chk("rst_err", 32'(bus.sym_err), 0);
    model_clear();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int         strobes, steps, last_cyc;
    logic       en;
    logic [1:0] sym;
    apply_reset();
    strobes  = 0;
    steps    = 0;
    last_cyc = 0;
    while (strobes < 6 && steps < 6 * v.period + 20) begin
      en  = 1'b1;
      sym = 2'b01;
      case (v.mode)
        1: sym = 2'b11;
        2: sym = 2'b00;
        3: sym = (steps % 2 == 0) ? 2'b01 : 2'b11;
        4: en  = (steps % 2 == 0);
        default: sym = 2'b01;
      endcase
      step(en, sym);
      steps++;
      if (bus.dout_valid) begin
        strobes++;
        if (strobes >= 2) chk({v.name, "_period"}, 32'(cyc - last_cyc), 32'(v.period));
        last_cyc = cyc;
        if (strobes >= 4) chk({v.name, "_steady"}, 32'(bus.dout), 32'(v.steady));
      end
    end
    chk({v.name, "_strobes"}, 32'(strobes), 6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int               k;
    logic [T_BITS-1:0] mn;
    int               strobes;
    bus.sample_en = 1'b0;
    bus.pwm_in    = 2'b00;
    cyc = 0;
    model_clear();
    #2;

    vecs[0] = '{"const_p1", 0, 15'h2000, R};
    vecs[1] = '{"const_m1", 1, 15'h6000, R};
    vecs[2] = '{"const_0",  2, 15'h0000, R};
    vecs[3] = '{"alt",      3, 15'h0000, R};
    vecs[4] = '{"en_half",  4, 15'h2000, 2 * R};
    foreach (vecs[i]) run_vec(vecs[i]);

    // Single illegal symbol inside a +1 stream.
    apply_reset();
    mn = 15'h2000;
    strobes = 0;
    for (int i = 0; i < 8 * R; i++) begin
      step(1'b1, (i == 300) ? 2'b10 : 2'b01);
      if (i == 299) chk("err_before", 32'(bus.sym_err), 0);
      if (i == 300) chk("err_set", 32'(bus.sym_err), 1);
      if (bus.dout_valid) begin
        strobes++;
        if (strobes >= 4 && bus.dout < mn) mn = bus.dout;
      end
    end
    chk("err_dip", 32'(mn < 15'h2000), 1);
    chk("err_recover", 32'(bus.dout), 32'h2000);
    chk("err_sticky", 32'(bus.sym_err), 1);

    // Illegal symbol landing on the tick cycle.
    apply_reset();
    for (int i = 0; i < R - 1; i++) step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    chk("tick_illegal_valid", 32'(bus.dout_valid), 1);
    chk("tick_illegal_err", 32'(bus.sym_err), 1);

    // Reset arriving while a strobe is showing.
    apply_reset();
    for (int i = 0; i < R; i++) step(1'b1, 2'b01);
    reset = 1'b0;
    #1;
    chk("drop_valid", 32'(bus.dout_valid), 0);
    chk("drop_dout", 32'(bus.dout), 0);
    model_clear();
    @(posedge clock);
    #1;
    chk("drop_valid_hold", 32'(bus.dout_valid), 0);
    reset = 1'b1;

    // Reset 100 cycles into a +1 stream, mid-window.
    apply_reset();
    for (int i = 0; i < 100; i++) step(1'b1, 2'b01);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_dout", 32'(bus.dout), 0);
    chk("mid_rst_valid", 32'(bus.dout_valid), 0);
    model_clear();
    @(posedge clock);
    #1;
    chk("mid_rst_hold", 32'(bus.dout_valid), 0);
    reset = 1'b1;
    k = 0;
    do begin
      step(1'b1, 2'b01);
      k++;
    end while (!bus.dout_valid && k < 200);
    chk("mid_rst_first_strobe", 32'(k), 32'(R));
    for (int i = k; i < 4 * R; i++) step(1'b1, 2'b01);
    chk("mid_rst_settled", 32'(bus.dout), 32'h2000);

    // Random symbols and enable gaps against the model.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] s;
      int         r;
      r = $urandom_range(0, 15);
      s = (r == 0) ? 2'b10 : (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : 2'b11;
      step($urandom_range(0, 3) != 0, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
